// File: rtl/cam_capture_if.sv
// Camera byte-stream input and frame-buffer write bus for cam_capture.
// master drives the camera side; slave is the capture block.
interface cam_capture_if #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_WIDTH = 8
);
   localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT) + 1;
   localparam int HW = $clog2(IMG_WIDTH);
   localparam int VW = $clog2(IMG_HEIGHT);

   logic                  w_req;
   logic                  cam_vsync;
   logic                  cam_href;
   logic                  cam_valid;
   logic [7:0]            cam_data;
   logic                  mem_we;
   logic [AW-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [HW-1:0]         hcount;
   logic [VW-1:0]         vcount;
   logic                  busy;
   logic                  frame_done;
   logic                  frame_err;

   modport master (
      output w_req, cam_vsync, cam_href, cam_valid, cam_data,
      input  mem_we, mem_addr, mem_din, hcount, vcount, busy, frame_done, frame_err
   );

   modport slave (
      input  w_req, cam_vsync, cam_href, cam_valid, cam_data,
      output mem_we, mem_addr, mem_din, hcount, vcount, busy, frame_done, frame_err
   );
endinterface

// File: rtl/cam_capture.sv
// Captures whole RGB565 camera frames on request, converts each pixel to 8-bit
// grayscale and emits frame-buffer writes with line-aligned addresses.
module cam_capture #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   cam_capture_if.slave cap
);
   localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT) + 1;
   localparam int HW = $clog2(IMG_WIDTH);
   localparam int VW = $clog2(IMG_HEIGHT);
   localparam int CW = HW + 1;
   localparam int RW = VW + 1;
   localparam logic [AW-1:0] FRAME_PX = AW'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [AW-1:0] LINE_PX  = AW'(IMG_WIDTH);
   localparam logic [CW-1:0] COLS     = CW'(IMG_WIDTH);
   localparam logic [RW-1:0] ROWS     = RW'(IMG_HEIGHT);

   typedef enum logic [1:0] {IDLE, ARM, SYNC, CAPTURE} state_t;

   state_t                state_q, state_d;
   logic                  vsync_q, href_q;
   logic                  phase_q, phase_d;
   logic [7:0]            hi_q, hi_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [AW-1:0]         ptr_q, ptr_d;
   logic [AW-1:0]         base_q, base_d;
   logic [AW-1:0]         pix_q, pix_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic                  we_q, we_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic vs_rise, vs_fall, hr_rise, hr_fall, phase_eff, byte_ok;

   function automatic logic [7:0] gray565(input logic [15:0] px);
      logic [7:0]  r8, g8, b8;
      logic [15:0] sum;
      r8  = {px[15:11], px[15:13]};
      g8  = {px[10:5], px[10:9]};
      b8  = {px[4:0], px[4:2]};
      sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
      return sum[15:8];
   endfunction

   assign vs_rise   = cap.cam_vsync & ~vsync_q;
   assign vs_fall   = ~cap.cam_vsync & vsync_q;
   assign hr_rise   = cap.cam_href & ~href_q;
   assign hr_fall   = ~cap.cam_href & href_q;
   assign phase_eff = hr_rise ? 1'b0 : phase_q;
   assign byte_ok   = cap.cam_href & cap.cam_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cap.w_req) state_d = ARM;
         ARM:     if (!cap.w_req) state_d = IDLE;
                  else if (vs_rise) state_d = SYNC;
         SYNC:    if (vs_fall) state_d = CAPTURE;
         CAPTURE: if (vs_rise) state_d = cap.w_req ? SYNC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      hi_d    = hi_q;
      col_d   = col_q;
      row_d   = row_q;
      ptr_d   = ptr_q;
      base_d  = base_q;
      pix_d   = pix_q;
      addr_d  = addr_q;
      din_d   = din_q;
      err_d   = err_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      if (state_q == SYNC && vs_fall) begin
         phase_d = 1'b0;
         col_d   = '0;
         row_d   = '0;
         ptr_d   = '0;
         base_d  = '0;
         pix_d   = '0;
         addr_d  = '0;
         err_d   = 1'b0;
      end else if (state_q == CAPTURE) begin
         if (byte_ok) begin
            phase_d = ~phase_eff;
            if (!phase_eff) begin
               hi_d = cap.cam_data;
            end else if (col_q < COLS && row_q < ROWS) begin
               we_d   = 1'b1;
               din_d  = gray565({hi_q, cap.cam_data});
               addr_d = ptr_q;
               ptr_d  = ptr_q + AW'(1);
               pix_d  = pix_q + AW'(1);
               col_d  = col_q + CW'(1);
            end
         end else if (hr_fall && col_q != '0 && row_q < ROWS) begin
            // short or full line: realign to the start of the next row
            phase_d = 1'b0;
            col_d   = '0;
            row_d   = row_q + RW'(1);
            base_d  = base_q + LINE_PX;
            ptr_d   = base_d;
         end else if (hr_fall || hr_rise) begin
            phase_d = 1'b0;
         end
         if (vs_rise) begin
            done_d = 1'b1;
            err_d  = (pix_d != FRAME_PX);
         end
      end else begin
         phase_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         phase_q <= 1'b0;
         hi_q    <= '0;
         col_q   <= '0;
         row_q   <= '0;
         ptr_q   <= '0;
         base_q  <= '0;
         pix_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         vsync_q <= cap.cam_vsync;
         href_q  <= cap.cam_href;
         phase_q <= phase_d;
         hi_q    <= hi_d;
         col_q   <= col_d;
         row_q   <= row_d;
         ptr_q   <= ptr_d;
         base_q  <= base_d;
         pix_q   <= pix_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cap.mem_we     = we_q;
   assign cap.mem_addr   = addr_q;
   assign cap.mem_din    = din_q;
   assign cap.hcount     = (col_q >= COLS) ? HW'(IMG_WIDTH - 1) : col_q[HW-1:0];
   assign cap.vcount     = row_q[VW-1:0];
   assign cap.busy       = (state_q == SYNC) || (state_q == CAPTURE);
   assign cap.frame_done = done_q;
   assign cap.frame_err  = err_q;
endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a small 8x5 image so whole frames stay short.
module tb_cam_capture;
   localparam int W = 8;
   localparam int H = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cam_capture_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) cif ();
   cam_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .cap (cif)
   );

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   int log_addr [1024];
   int log_din [1024];
   logic err_at_done = 1'b0;

   always @(negedge clk) begin
      if (cif.mem_we) begin
         if (wr_cnt < 1024) begin
            log_addr[wr_cnt] <= int'(cif.mem_addr);
            log_din[wr_cnt]  <= int'(cif.mem_din);
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (cif.frame_done) begin
         done_cnt    <= done_cnt + 1;
         err_at_done <= cif.frame_err;
      end
      if (cif.busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      cif.cam_valid = 1'b1;
      cif.cam_data  = b;
      @(negedge clk);
      cif.cam_valid = 1'b0;
   endtask

   task automatic send_lines(input int n, input int npix, input logic [7:0] hi, input logic [7:0] lo);
      for (int l = 0; l < n; l++) begin
         @(negedge clk);
         cif.cam_href = 1'b1;
         for (int p = 0; p < npix; p++) begin
            send_byte(hi);
            send_byte(lo);
         end
         @(negedge clk);
         cif.cam_href = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic vsync_pulse();
      @(negedge clk);
      cif.cam_vsync = 1'b1;
      repeat (3) @(negedge clk);
      cif.cam_vsync = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      int b, bb, d;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({cif.mem_we, cif.busy, cif.frame_done, cif.frame_err} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {cif.mem_we, cif.busy, cif.frame_done, cif.frame_err});
      end
      checks++;
      if (cif.mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", cif.mem_addr); end
      checks++;
      if (cif.mem_din !== '0) begin failures++; $display("FAIL reset_din got=%0h exp=0", cif.mem_din); end
      checks++;
      if ({cif.hcount, cif.vcount} !== '0) begin
         failures++;
         $display("FAIL reset_counts got h=%0d v=%0d exp=0", cif.hcount, cif.vcount);
      end
      rst = 1'b0;
      #1;
      b = wr_cnt; bb = busy_cnt; d = done_cnt;
      vsync_pulse();
      send_lines(H, W, 8'hFF, 8'hFF);
      vsync_pulse();
      checks++;
      if (wr_cnt - b !== 0) begin failures++; $display("FAIL idle_writes got=%0d exp=0", wr_cnt - b); end
      checks++;
      if (busy_cnt - bb !== 0) begin failures++; $display("FAIL idle_busy got=%0d exp=0", busy_cnt - bb); end
      checks++;
      if (done_cnt - d !== 0) begin failures++; $display("FAIL idle_done got=%0d exp=0", done_cnt - d); end
   endtask

   task automatic test_conversion();
      logic [7:0] hi_t [5] = '{8'hF8, 8'h07, 8'h00, 8'h12, 8'hF8};
      logic [7:0] lo_t [5] = '{8'h00, 8'hE0, 8'h1F, 8'h34, 8'h00};
      logic [7:0] ex_t [5] = '{8'h4C, 8'h95, 8'h1C, 8'h3F, 8'h4C};
      int ad_t [5] = '{0, 1, 2, 3, 8};
      int d;
      d = done_cnt;
      cif.w_req = 1'b1;
      vsync_pulse();
      send_byte(8'h07);
      @(negedge clk);
      cif.cam_href = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            send_byte(8'hAA);
            @(negedge clk);
            cif.cam_href = 1'b0;
            repeat (2) @(negedge clk);
            cif.cam_href = 1'b1;
         end
         send_byte(hi_t[i]);
         @(negedge clk);
         checks++;
         if (cif.mem_we !== 1'b0) begin failures++; $display("FAIL conv_pre_we[%0d] got=%b exp=0", i, cif.mem_we); end
         cif.cam_valid = 1'b1;
         cif.cam_data  = lo_t[i];
         @(negedge clk);
         cif.cam_valid = 1'b0;
         checks++;
         if (cif.mem_we !== 1'b1 || cif.mem_din !== ex_t[i]) begin
            failures++;
            $display("FAIL conv_din[%0d] got we=%b din=%0h exp we=1 din=%0h", i, cif.mem_we, cif.mem_din, ex_t[i]);
         end
         checks++;
         if (int'(cif.mem_addr) !== ad_t[i]) begin
            failures++;
            $display("FAIL conv_addr[%0d] got=%0d exp=%0d", i, cif.mem_addr, ad_t[i]);
         end
         @(negedge clk);
         checks++;
         if (cif.mem_we !== 1'b0) begin failures++; $display("FAIL conv_pulse[%0d] got=%b exp=0", i, cif.mem_we); end
      end
      @(negedge clk);
      cif.cam_href = 1'b0;
      repeat (2) @(negedge clk);
      cif.w_req = 1'b0;
      vsync_pulse();
      checks++;
      if (done_cnt - d !== 1) begin failures++; $display("FAIL conv_done got=%0d exp=1", done_cnt - d); end
      checks++;
      if (err_at_done !== 1'b1 || cif.frame_err !== 1'b1) begin
         failures++;
         $display("FAIL conv_err got=%b/%b exp=1/1", err_at_done, cif.frame_err);
      end
   endtask

   task automatic test_full_frame();
      int b, d, bad_din, bad_addr;
      b = wr_cnt; d = done_cnt;
      cif.w_req = 1'b1;
      vsync_pulse();
      checks++;
      if (cif.busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b exp=1", cif.busy); end
      send_lines(H, W, 8'hFF, 8'hFF);
      checks++;
      if (cif.vcount !== 3'(H) || cif.hcount !== 3'd0) begin
         failures++;
         $display("FAIL full_counts got h=%0d v=%0d exp h=0 v=%0d", cif.hcount, cif.vcount, H);
      end
      cif.w_req = 1'b0;
      vsync_pulse();
      bad_din = 0; bad_addr = 0;
      for (int i = 0; i < W * H; i++) begin
         if (log_din[b+i] != 8'hFF) bad_din++;
         if (log_addr[b+i] != i) bad_addr++;
      end
      checks++;
      if (wr_cnt - b !== W * H) begin failures++; $display("FAIL full_writes got=%0d exp=%0d", wr_cnt - b, W * H); end
      checks++;
      if (bad_din !== 0) begin failures++; $display("FAIL full_din bad=%0d exp=0", bad_din); end
      checks++;
      if (bad_addr !== 0) begin failures++; $display("FAIL full_addr_seq bad=%0d exp=0", bad_addr); end
      checks++;
      if (log_addr[b+W*H-1] !== W * H - 1) begin
         failures++;
         $display("FAIL full_last_addr got=%0d exp=%0d", log_addr[b+W*H-1], W * H - 1);
      end
      checks++;
      if (done_cnt - d !== 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt - d); end
      checks++;
      if (err_at_done !== 1'b0) begin failures++; $display("FAIL full_err got=%b exp=0", err_at_done); end
      checks++;
      if (cif.busy !== 1'b0) begin failures++; $display("FAIL full_idle_busy got=%b exp=0", cif.busy); end
   endtask

   task automatic test_mid_frame_arm();
      int b, d;
      b = wr_cnt; d = done_cnt;
      vsync_pulse();
      send_lines(2, W, 8'hFF, 8'hFF);
      cif.w_req = 1'b1;
      send_lines(H - 2, W, 8'hFF, 8'hFF);
      #1;
      checks++;
      if (wr_cnt - b !== 0) begin failures++; $display("FAIL arm_partial_writes got=%0d exp=0", wr_cnt - b); end
      checks++;
      if (cif.busy !== 1'b0) begin failures++; $display("FAIL arm_busy got=%b exp=0", cif.busy); end
      vsync_pulse();
      send_lines(H, W, 8'h07, 8'hE0);
      cif.w_req = 1'b0;
      vsync_pulse();
      checks++;
      if (wr_cnt - b !== W * H) begin failures++; $display("FAIL arm_writes got=%0d exp=%0d", wr_cnt - b, W * H); end
      checks++;
      if (log_addr[b] !== 0 || log_din[b] !== 8'h95) begin
         failures++;
         $display("FAIL arm_first got addr=%0d din=%0h exp addr=0 din=95", log_addr[b], log_din[b]);
      end
      checks++;
      if (log_addr[b+W*H-1] !== W * H - 1) begin
         failures++;
         $display("FAIL arm_last_addr got=%0d exp=%0d", log_addr[b+W*H-1], W * H - 1);
      end
      checks++;
      if (done_cnt - d !== 1 || err_at_done !== 1'b0) begin
         failures++;
         $display("FAIL arm_done got done=%0d err=%b exp done=1 err=0", done_cnt - d, err_at_done);
      end
   endtask

   task automatic test_short_long();
      int b, d;
      b = wr_cnt; d = done_cnt;
      cif.w_req = 1'b1;
      vsync_pulse();
      send_lines(1, W - 2, 8'hF8, 8'h00);
      send_lines(1, W + 2, 8'hF8, 8'h00);
      send_lines(H - 1, W, 8'hF8, 8'h00);
      checks++;
      if (cif.vcount !== 3'(H)) begin failures++; $display("FAIL sl_vcount_sat got=%0d exp=%0d", cif.vcount, H); end
      cif.w_req = 1'b0;
      vsync_pulse();
      checks++;
      if (wr_cnt - b !== W * H - 2) begin failures++; $display("FAIL sl_writes got=%0d exp=%0d", wr_cnt - b, W * H - 2); end
      checks++;
      if (log_addr[b+W-3] !== W - 3) begin failures++; $display("FAIL sl_line0_last got=%0d exp=%0d", log_addr[b+W-3], W - 3); end
      checks++;
      if (log_addr[b+W-2] !== W) begin failures++; $display("FAIL sl_line1_first got=%0d exp=%0d", log_addr[b+W-2], W); end
      checks++;
      if (log_addr[b+2*W-2] !== 2 * W) begin
         failures++;
         $display("FAIL sl_line2_first got=%0d exp=%0d", log_addr[b+2*W-2], 2 * W);
      end
      checks++;
      if (log_addr[b+W*H-3] !== W * H - 1 || log_din[b+W*H-3] !== 8'h4C) begin
         failures++;
         $display("FAIL sl_last got addr=%0d din=%0h exp addr=%0d din=4c", log_addr[b+W*H-3], log_din[b+W*H-3], W * H - 1);
      end
      checks++;
      if (done_cnt - d !== 1 || err_at_done !== 1'b1) begin
         failures++;
         $display("FAIL sl_done_err got done=%0d err=%b exp done=1 err=1", done_cnt - d, err_at_done);
      end
   endtask

   task automatic test_async_reset();
      int b;
      cif.w_req = 1'b1;
      vsync_pulse();
      send_lines(2, W, 8'hFF, 8'hFF);
      @(negedge clk);
      cif.cam_href = 1'b1;
      for (int p = 0; p < 3; p++) begin
         send_byte(8'hFF);
         send_byte(8'hFF);
      end
      checks++;
      if (cif.mem_we !== 1'b1 || int'(cif.mem_addr) !== 2 * W + 2) begin
         failures++;
         $display("FAIL ar_pre got we=%b addr=%0d exp we=1 addr=%0d", cif.mem_we, cif.mem_addr, 2 * W + 2);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({cif.mem_we, cif.busy, cif.frame_done} !== 3'b0 || cif.mem_addr !== '0 || cif.mem_din !== '0) begin
         failures++;
         $display("FAIL ar_outputs got we=%b busy=%b addr=%0d din=%0h exp 0", cif.mem_we, cif.busy, cif.mem_addr, cif.mem_din);
      end
      checks++;
      if ({cif.hcount, cif.vcount} !== '0) begin
         failures++;
         $display("FAIL ar_counts got h=%0d v=%0d exp=0", cif.hcount, cif.vcount);
      end
      cif.cam_href = 1'b0;
      cif.w_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      b = wr_cnt;
      send_lines(2, W, 8'hFF, 8'hFF);
      cif.w_req = 1'b1;
      repeat (2) @(negedge clk);
      send_lines(2, W, 8'hFF, 8'hFF);
      #1;
      checks++;
      if (wr_cnt - b !== 0) begin failures++; $display("FAIL ar_no_writes got=%0d exp=0", wr_cnt - b); end
      checks++;
      if (cif.busy !== 1'b0) begin failures++; $display("FAIL ar_armed_busy got=%b exp=0", cif.busy); end
      cif.w_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cif.w_req = 1'b0;
      cif.cam_vsync = 1'b0;
      cif.cam_href = 1'b0;
      cif.cam_valid = 1'b0;
      cif.cam_data = 8'h00;
      test_reset();
      test_conversion();
      test_full_frame();
      test_mid_frame_arm();
      test_short_long();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Upstream stage of the camera frame buffer top.
- Receives the camera's byte stream (vsync, href, 8-bit data with a one-cycle per-byte valid strobe, already synchronised into clk).
- Assembles RGB565 pixel pairs and converts each pixel to 8-bit grayscale.
- Generates the frame-buffer write strobe, address, data, and the hcount/vcount position counters; captures whole frames only while w_req is high.

Parameters:
IMG_WIDTH, 640, active pixels per line
IMG_HEIGHT, 480, active lines per frame
DATA_WIDTH, 8, grayscale output width (fixed at 8 in this revision)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
w_req  in  1  capture request (level)
cam_vsync  in  1  frame sync, high between frames
cam_href  in  1  line valid
cam_valid  in  1  one-cycle strobe, cam_data valid this cycle
cam_data  in  8  camera byte
mem_we  out  1  frame-buffer write enable
mem_addr  out  $clog2(IMG_WIDTH*IMG_HEIGHT)+1  write address, matches frame-buffer address width
mem_din  out  DATA_WIDTH  grayscale pixel
hcount  out  $clog2(IMG_WIDTH)  column of current/next pixel
vcount  out  $clog2(IMG_HEIGHT)  current line
busy  out  1  high in SYNC or CAPTURE
frame_done  out  1  one-cycle pulse at end of a captured frame
frame_err  out  1  sticky: last frame pixel count != IMG_WIDTH*IMG_HEIGHT

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, byte phase=0, counters=0.
- Edge detection uses registered copies of cam_vsync and cam_href; edges act one cycle after the input change.
- FSM: four states.
  - IDLE: w_req=1 -> ARM.
  - ARM: vsync rising edge -> SYNC. w_req=0 -> IDLE.
  - SYNC: vsync falling edge -> CAPTURE. Entering CAPTURE clears hcount, vcount, mem_addr, frame_err.
  - CAPTURE: vsync rising edge -> pulse frame_done for 1 cycle. frame_err is set in that same cycle if the written-pixel count != IMG_WIDTH*IMG_HEIGHT. Next state is SYNC if w_req=1, else IDLE.
- w_req deasserted mid-frame does not abort the frame: the current frame completes.
- ARM only ever starts on a full frame. A partial frame in progress when w_req rises is never written.
- Byte assembly (CAPTURE with href=1 only):
  - Byte phase toggles on each cam_valid.
  - Phase 0 latches the high byte: R5=d[7:3], G6 high bits=d[2:0].
  - Phase 1 completes the pixel: G6 low bits=d[7:5], B5=d[4:0].
  - Phase resets to 0 on href rising edge. A dangling phase-0 byte at href fall is discarded.
- Conversion:
  - Expand to 8 bits: r8={R5,R5[4:2]}, g8={G6,G6[5:4]}, b8={B5,B5[4:2]}.
  - gray=(77*r8+150*g8+29*b8)>>8, using a 16-bit unsigned sum with no overflow.
- Latency: mem_we, mem_din and mem_addr are registered together and valid exactly 1 cycle after the phase-1 cam_valid.
- Write gating: a write occurs only if hcount<IMG_WIDTH and vcount<IMG_HEIGHT. Excess pixels or lines are dropped and not counted.
- Counters:
  - After each write: hcount+1 (saturates at IMG_WIDTH-1 for the write window) and mem_addr+1.
  - On href falling edge with ≥1 pixel in the line: hcount=0, vcount+1 (saturating at IMG_HEIGHT), mem_addr=vcount_next*IMG_WIDTH.
  - Short lines therefore re-align to the next row.
- Simultaneous events:
  - A vsync rising edge in the same cycle as a pending write: the write completes, then frame_done follows in the next cycle.
  - cam_valid while href=0 or outside CAPTURE is ignored.
- Mid-operation reset returns to IDLE immediately. Any in-flight write is dropped (mem_we=0).

Test Plan:
- Reset then idle: rst pulse, w_req=0, stream one frame -> mem_we never asserts, busy=0, all outputs 0.
- Full frame: w_req=1, frame of 480 lines x 1280 bytes all 0xFFFF -> 307200 writes, mem_din=0xFF, last mem_addr=307199, frame_done one pulse, frame_err=0.
- Conversion: pixel bytes 0xF8,0x00 (pure red) -> mem_din=0x4C; 0x07,0xE0 (green) -> 0x95; 0x00,0x1F (blue) -> 0x1C; 1-cycle latency after second byte.
- Mid-frame arm: w_req rises during line 100 of a frame -> no writes until the following vsync rise/fall, then the next frame starts at mem_addr 0.
- Short/long lines: line 0 with 600 pixels, line 1 with 700 pixels -> line 1 first write at addr 640, pixels 640..699 dropped, frame_err=1 at frame_done.
- Async reset during CAPTURE at addr 1000 -> outputs 0 same cycle, state IDLE, no further writes until w_req and a fresh vsync.
